// File: rtl/edge_detection_stream_router.sv
// edge_detection_stream_router: Avalon-ST demux steering whole frames to bypass (out0) or edge path (out1).
// Latency 1 cycle through a single output register; sustains one beat per cycle.
// Backpressure: stream_in_ready = ~ov | ready of the sink the held beat targets; the other sink's ready is ignored.
// Optional build macro STREAM_ROUTER_DROP_ORPHAN_EN: non-SOP beats arriving outside a frame are accepted and discarded.
module edge_detection_stream_router #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sel,
  input  logic [DW-1:0] stream_in_data,
  input  logic          stream_in_startofpacket,
  input  logic          stream_in_endofpacket,
  input  logic          stream_in_valid,
  output logic          stream_in_ready,
  output logic [DW-1:0] stream_out0_data,
  output logic          stream_out0_startofpacket,
  output logic          stream_out0_endofpacket,
  output logic          stream_out0_valid,
  input  logic          stream_out0_ready,
  output logic [DW-1:0] stream_out1_data,
  output logic          stream_out1_startofpacket,
  output logic          stream_out1_endofpacket,
  output logic          stream_out1_valid,
  input  logic          stream_out1_ready,
  output logic          active_sel,
  output logic          frame_active
);

  typedef enum logic {S_IDLE = 1'b0, S_FRAME = 1'b1} state_t;

  state_t        r_state;
  logic [DW-1:0] r_data;
  logic          r_sop;
  logic          r_eop;
  logic          r_ov;
  logic          r_dest;
  logic          r_active_sel;

  logic          w_dest_ready;
  logic          w_accept;
  logic          w_route;
  logic          w_load;

  assign w_dest_ready    = r_dest ? stream_out1_ready : stream_out0_ready;
  assign stream_in_ready = ~r_ov | w_dest_ready;
  assign w_accept        = stream_in_valid & stream_in_ready;

  // SOP beats follow the live select; everything else follows the frame's latched select.
  assign w_route = stream_in_startofpacket ? sel : r_active_sel;

`ifdef STREAM_ROUTER_DROP_ORPHAN_EN
  // Orphans (non-SOP while idle) are consumed but never enter the output register.
  assign w_load = w_accept & (stream_in_startofpacket | (r_state == S_FRAME));
`else
  assign w_load = w_accept;
`endif

  // Output register: load on accepted beat, drain when the targeted sink takes it, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      r_ov   <= 1'b0;
      r_dest <= 1'b0;
    end else if (w_load) begin
      r_data <= stream_in_data;
      r_sop  <= stream_in_startofpacket;
      r_eop  <= stream_in_endofpacket;
      r_ov   <= 1'b1;
      r_dest <= w_route;
    end else if (r_ov && w_dest_ready) begin
      r_ov   <= 1'b0;
    end
  end

  // Frame tracker: latch select on every accepted SOP (also re-latches on a truncating SOP).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_active_sel <= 1'b0;
    end else if (w_accept) begin
      if (stream_in_startofpacket) begin
        r_active_sel <= sel;
        r_state      <= stream_in_endofpacket ? S_IDLE : S_FRAME;
      end else if ((r_state == S_FRAME) && stream_in_endofpacket) begin
        r_state      <= S_IDLE;
      end
    end
  end

  assign stream_out0_data          = r_data;
  assign stream_out0_startofpacket = r_sop;
  assign stream_out0_endofpacket   = r_eop;
  assign stream_out0_valid         = r_ov & ~r_dest;
  assign stream_out1_data          = r_data;
  assign stream_out1_startofpacket = r_sop;
  assign stream_out1_endofpacket   = r_eop;
  assign stream_out1_valid         = r_ov & r_dest;
  assign active_sel                = r_active_sel;
  assign frame_active              = (r_state == S_FRAME);

endmodule

// File: tb/tb_edge_detection_stream_router.sv
// Directed bench for edge_detection_stream_router: frame routing, sel latching,
// backpressure hold, single-beat and truncated frames, reset and orphan beats.
module tb_edge_detection_stream_router;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sel;
  logic [DW-1:0] in_data;
  logic          in_sop, in_eop, in_valid, in_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic          out0_sop, out0_eop, out0_valid, out0_ready;
  logic          out1_sop, out1_eop, out1_valid, out1_ready;
  logic          active_sel, frame_active;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  edge_detection_stream_router #(.DW(DW)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .sel                       (sel),
    .stream_in_data            (in_data),
    .stream_in_startofpacket   (in_sop),
    .stream_in_endofpacket     (in_eop),
    .stream_in_valid           (in_valid),
    .stream_in_ready           (in_ready),
    .stream_out0_data          (out0_data),
    .stream_out0_startofpacket (out0_sop),
    .stream_out0_endofpacket   (out0_eop),
    .stream_out0_valid         (out0_valid),
    .stream_out0_ready         (out0_ready),
    .stream_out1_data          (out1_data),
    .stream_out1_startofpacket (out1_sop),
    .stream_out1_endofpacket   (out1_eop),
    .stream_out1_valid         (out1_valid),
    .stream_out1_ready         (out1_ready),
    .active_sel                (active_sel),
    .frame_active              (frame_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic sop, input logic eop, input logic [DW-1:0] d);
    in_valid = v;
    in_sop   = sop;
    in_eop   = eop;
    in_data  = d;
  endtask

  // Present one beat and let it be accepted on the next edge.
  task automatic send(input logic sop, input logic eop, input logic [DW-1:0] d);
    drv(1'b1, sop, eop, d);
    tick();
  endtask

  // The beat just accepted must sit on exactly the named port.
  task automatic chk_beat(input string tag, input logic port, input logic sop, input logic eop,
                          input logic [DW-1:0] d);
    chk({tag, "_v0"}, out0_valid, {31'd0, ~port});
    chk({tag, "_v1"}, out1_valid, {31'd0, port});
    chk({tag, "_dat"}, port ? out1_data : out0_data, d);
    chk({tag, "_sop"}, port ? out1_sop : out0_sop, sop);
    chk({tag, "_eop"}, port ? out1_eop : out0_eop, eop);
  endtask

  initial begin
    reset_n    = 1'b0;
    sel        = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drv(1'b0, 1'b0, 1'b0, '0);

    // Reset state
    repeat (2) tick();
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_dat", out0_data, 0);
    chk("rst_sop", out0_sop, 0);
    chk("rst_eop", out0_eop, 0);
    chk("rst_asel", active_sel, 0);
    chk("rst_fa", frame_active, 0);
    chk("rst_rdy", in_ready, 1);
    reset_n = 1'b1;
    tick();

    // 4-beat frame, sel=0 -> out0
    sel = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(k == 1, k == 4, DW'(k));
      chk_beat("f1", 1'b0, k == 1, k == 4, DW'(k));
      chk("f1_fa", frame_active, {31'd0, k != 4});
    end
    chk("f1_asel", active_sel, 0);
    drv(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("f1_idle_v0", out0_valid, 0);
    chk("f1_idle_v1", out1_valid, 0);

    // 8-beat frame with sel=1, sel drops to 0 at beat 2 -> whole frame still on out1
    sel = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) sel = 1'b0;
      send(k == 0, k == 7, DW'(24'h10 + k));
      chk_beat("f2", 1'b1, k == 0, k == 7, DW'(24'h10 + k));
    end
    chk("f2_asel", active_sel, 1);
    drv(1'b0, 1'b0, 1'b0, '0);
    tick();
    // Next frame follows the new sel=0
    send(1'b1, 1'b0, 24'h000020);
    chk_beat("f2n_a", 1'b0, 1'b1, 1'b0, 24'h000020);
    chk("f2n_asel", active_sel, 0);
    send(1'b0, 1'b1, 24'h000021);
    chk_beat("f2n_b", 1'b0, 1'b0, 1'b1, 24'h000021);
    drv(1'b0, 1'b0, 1'b0, '0);
    tick();

    // Backpressure on out1 for 3 cycles; out0_ready held low and irrelevant
    out0_ready = 1'b0;
    sel = 1'b1;
    send(1'b1, 1'b0, 24'h000030);
    chk_beat("bp0", 1'b1, 1'b1, 1'b0, 24'h000030);
    send(1'b0, 1'b0, 24'h000031);
    chk_beat("bp1", 1'b1, 1'b0, 1'b0, 24'h000031);
    out1_ready = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 24'h000032);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall_rdy", in_ready, 0);
      tick();
      chk_beat("bp_hold", 1'b1, 1'b0, 1'b0, 24'h000031);
    end
    out1_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    tick();
    chk_beat("bp2", 1'b1, 1'b0, 1'b0, 24'h000032);
    for (int k = 3; k < 6; k++) begin
      send(1'b0, k == 5, DW'(24'h30 + k));
      chk_beat("bp_tail", 1'b1, 1'b0, k == 5, DW'(24'h30 + k));
    end
    drv(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("bp_drain_v1", out1_valid, 0);
    out0_ready = 1'b1;

    // Single-beat packet to out1
    sel = 1'b1;
    send(1'b1, 1'b1, 24'hABCDEF);
    chk_beat("sb", 1'b1, 1'b1, 1'b1, 24'hABCDEF);
    chk("sb_fa", frame_active, 0);
    chk("sb_asel", active_sel, 1);
    drv(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("sb_after_v1", out1_valid, 0);

    // Truncated frame: new SOP after 2 beats with sel now 0
    sel = 1'b1;
    send(1'b1, 1'b0, 24'h000050);
    chk_beat("tr0", 1'b1, 1'b1, 1'b0, 24'h000050);
    send(1'b0, 1'b0, 24'h000051);
    chk_beat("tr1", 1'b1, 1'b0, 1'b0, 24'h000051);
    sel = 1'b0;
    send(1'b1, 1'b0, 24'h000052);
    chk_beat("tr_sop", 1'b0, 1'b1, 1'b0, 24'h000052);
    chk("tr_asel", active_sel, 0);
    chk("tr_fa", frame_active, 1);
    send(1'b0, 1'b1, 24'h000053);
    chk_beat("tr_eop", 1'b0, 1'b0, 1'b1, 24'h000053);
    chk("tr_fa_end", frame_active, 0);

    // Reset mid-frame clears register and state at once
    sel = 1'b1;
    send(1'b1, 1'b0, 24'h00005F);
    chk("mr_fa_pre", frame_active, 1);
    drv(1'b0, 1'b0, 1'b0, '0);
    reset_n = 1'b0;
    #2;
    chk("mr_v1", out1_valid, 0);
    chk("mr_fa", frame_active, 0);
    chk("mr_asel", active_sel, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Two orphan beats after reset, then a proper frame with sel=1
    sel = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, 1'b0, 1'b0, DW'(24'h60 + k));
      #1;
      chk("orph_rdy", in_ready, 1);
      tick();
`ifdef STREAM_ROUTER_DROP_ORPHAN_EN
      chk("orph_drop_v0", out0_valid, 0);
      chk("orph_drop_v1", out1_valid, 0);
`else
      chk_beat("orph_fwd", 1'b0, 1'b0, 1'b0, DW'(24'h60 + k));
`endif
      chk("orph_fa", frame_active, 0);
    end
    send(1'b1, 1'b0, 24'h000062);
    chk_beat("orph_f0", 1'b1, 1'b1, 1'b0, 24'h000062);
    send(1'b0, 1'b1, 24'h000063);
    chk_beat("orph_f1", 1'b1, 1'b0, 1'b1, 24'h000063);
    drv(1'b0, 1'b0, 1'b0, '0);
    tick();
    chk("end_v0", out0_valid, 0);
    chk("end_v1", out1_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
